// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline it steers.
// The pipeline side is the master; the controller is the slave.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             id_branch_taken;
  logic             idex_stall;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [15:0]      load_use_events;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, id_branch_taken,
    input  idex_stall, pc_write, ifid_write, ifid_flush, busy,
           stall_cycles, load_use_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, id_branch_taken,
    output idex_stall, pc_write, ifid_write, ifid_flush, busy,
           stall_cycles, load_use_events
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall / bubble sequencer for the ID/EX register, plus taken-branch
// IF/ID flush and hazard performance counters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | normal issue; hazard and branch decode are combinational
//   ST_WAIT | extra bubbles after a load-use hazard (BUBBLES > 1 only)
module hazard_stall_ctrl #(
  parameter int BUBBLES = 1,
  parameter int CNT_W   = 32
) (
  input logic              clk,
  input logic              rst_n,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] REMAIN_INIT = 2'(BUBBLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       remain, remain_nxt;
  logic             hz;
  logic             lu_hit;
  logic             idex_stall;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [15:0]      lu_cnt;

  // $zero is never a real load destination, so it can never hazard.
  assign hz = bus.ex_memread && (bus.ex_rt != 5'd0) &&
              ((bus.ex_rt == bus.id_rs) ||
               (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      remain    <= 2'd0;
      stall_cnt <= '0;
      lu_cnt    <= 16'd0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
      if (idex_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (lu_hit)     lu_cnt    <= lu_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    lu_hit     = 1'b0;
    idex_stall = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    if (!rst_n) begin
      // Fill the front-end registers with bubbles while held in reset.
      idex_stall = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (hz) begin
            // Hazard wins over a taken branch; the branch re-resolves later.
            idex_stall = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            lu_hit     = 1'b1;
            if (BUBBLES > 1) begin
              state_nxt  = ST_WAIT;
              remain_nxt = REMAIN_INIT;
            end
          end else if (bus.id_branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        ST_WAIT: begin
          idex_stall = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          remain_nxt = remain - 2'd1;
          if (remain == 2'd1) state_nxt = ST_RUN;
        end
        default: begin
          state_nxt  = ST_RUN;
          remain_nxt = 2'd0;
        end
      endcase
    end
  end

  assign bus.idex_stall      = idex_stall;
  assign bus.pc_write        = pc_write;
  assign bus.ifid_write      = ifid_write;
  assign bus.ifid_flush      = ifid_flush;
  assign bus.busy            = (state == ST_WAIT);
  assign bus.stall_cycles    = stall_cnt;
  assign bus.load_use_events = lu_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (BUBBLES=1/CNT_W=32,
// BUBBLES=3/CNT_W=8, BUBBLES=1/CNT_W=4) share one stimulus stream.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs, rt, ex_rt;
  logic       uses, mr, br;

  int total_cnt = 0;
  int pass_cnt  = 0;

  hazard_stall_ctrl_if #(.CNT_W(32)) if0 ();
  hazard_stall_ctrl_if #(.CNT_W(8))  if1 ();
  hazard_stall_ctrl_if #(.CNT_W(4))  if2 ();

  assign if0.id_rs = rs;  assign if0.id_rt = rt;  assign if0.id_uses_rt = uses;
  assign if0.ex_memread = mr;  assign if0.ex_rt = ex_rt;  assign if0.id_branch_taken = br;
  assign if1.id_rs = rs;  assign if1.id_rt = rt;  assign if1.id_uses_rt = uses;
  assign if1.ex_memread = mr;  assign if1.ex_rt = ex_rt;  assign if1.id_branch_taken = br;
  assign if2.id_rs = rs;  assign if2.id_rt = rt;  assign if2.id_uses_rt = uses;
  assign if2.ex_memread = mr;  assign if2.ex_rt = ex_rt;  assign if2.id_branch_taken = br;

  hazard_stall_ctrl #(.BUBBLES(1), .CNT_W(32)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  hazard_stall_ctrl #(.BUBBLES(3), .CNT_W(8))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  hazard_stall_ctrl #(.BUBBLES(1), .CNT_W(4))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bubbles still owed, plus event tallies.
  int     nb[3] = '{1, 3, 1};
  int     cw[3] = '{32, 8, 4};
  int     left[3];
  longint stalls[3];
  longint events[3];

  // Pre-edge output samples and post-edge counter samples per instance.
  logic   a_st[3], a_pw[3], a_iw[3], a_fl[3], a_bz[3];
  longint p_sc[3], p_ev[3];

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic model_hz();
    return mr && (ex_rt != 5'd0) && ((ex_rt == rs) || (uses && (ex_rt == rt)));
  endfunction

  task automatic sample_out();
    a_st[0] = if0.idex_stall; a_pw[0] = if0.pc_write; a_iw[0] = if0.ifid_write;
    a_fl[0] = if0.ifid_flush; a_bz[0] = if0.busy;
    a_st[1] = if1.idex_stall; a_pw[1] = if1.pc_write; a_iw[1] = if1.ifid_write;
    a_fl[1] = if1.ifid_flush; a_bz[1] = if1.busy;
    a_st[2] = if2.idex_stall; a_pw[2] = if2.pc_write; a_iw[2] = if2.ifid_write;
    a_fl[2] = if2.ifid_flush; a_bz[2] = if2.busy;
  endtask

  task automatic sample_cnt();
    p_sc[0] = longint'(if0.stall_cycles); p_ev[0] = longint'(if0.load_use_events);
    p_sc[1] = longint'(if1.stall_cycles); p_ev[1] = longint'(if1.load_use_events);
    p_sc[2] = longint'(if2.stall_cycles); p_ev[2] = longint'(if2.load_use_events);
  endtask

  // One clock: inputs already set (just after negedge); compare against the
  // model before the edge, advance the model, sample counters after the edge.
  task automatic cycle();
    logic e_st, e_pw, e_iw, e_fl, e_bz;
    logic hz_now;
    logic st_now[3];
    #2;
    sample_out();
    hz_now = model_hz();
    for (int k = 0; k < 3; k++) begin
      e_bz = (left[k] > 0);
      if (!rst_n) begin
        e_st = 1'b1; e_pw = 1'b0; e_iw = 1'b0; e_fl = 1'b1;
      end else if (left[k] > 0 || hz_now) begin
        e_st = 1'b1; e_pw = 1'b0; e_iw = 1'b0; e_fl = 1'b0;
      end else begin
        e_st = 1'b0; e_pw = 1'b1; e_iw = 1'b1; e_fl = br;
      end
      st_now[k] = e_st;
      chk($sformatf("d%0d.idex_stall", k), longint'(a_st[k]), longint'(e_st));
      chk($sformatf("d%0d.pc_write", k),   longint'(a_pw[k]), longint'(e_pw));
      chk($sformatf("d%0d.ifid_write", k), longint'(a_iw[k]), longint'(e_iw));
      chk($sformatf("d%0d.ifid_flush", k), longint'(a_fl[k]), longint'(e_fl));
      chk($sformatf("d%0d.busy", k),       longint'(a_bz[k]), longint'(e_bz));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        left[k] = 0; stalls[k] = 0; events[k] = 0;
      end else begin
        if (st_now[k]) stalls[k]++;
        if (left[k] > 0) left[k]--;
        else if (hz_now) begin
          events[k]++;
          left[k] = nb[k] - 1;
        end
      end
    end
    #1;
    sample_cnt();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d.stall_cycles", k), p_sc[k], stalls[k] % (64'd1 << cw[k]));
      chk($sformatf("d%0d.load_use_events", k), p_ev[k], events[k] % 64'd65536);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs = 5'd0; rt = 5'd0; ex_rt = 5'd0; uses = 1'b0; mr = 1'b0; br = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rs, rt, ex_rt;
    logic       uses, mr, br;
    logic       e_stall, e_flush, e_pcw;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{rs:8, rt:0, ex_rt:8, uses:0, mr:1, br:0, e_stall:1, e_flush:0, e_pcw:0};
    tbl[1] = '{rs:8, rt:0, ex_rt:8, uses:0, mr:0, br:0, e_stall:0, e_flush:0, e_pcw:1};
    tbl[2] = '{rs:3, rt:9, ex_rt:9, uses:1, mr:1, br:0, e_stall:1, e_flush:0, e_pcw:0};
    tbl[3] = '{rs:3, rt:9, ex_rt:9, uses:0, mr:1, br:0, e_stall:0, e_flush:0, e_pcw:1};
    tbl[4] = '{rs:0, rt:0, ex_rt:0, uses:1, mr:1, br:0, e_stall:0, e_flush:0, e_pcw:1};
    tbl[5] = '{rs:4, rt:6, ex_rt:7, uses:1, mr:1, br:1, e_stall:0, e_flush:1, e_pcw:1};
    tbl[6] = '{rs:5, rt:2, ex_rt:5, uses:1, mr:1, br:1, e_stall:1, e_flush:0, e_pcw:0};
    tbl[7] = '{rs:8, rt:8, ex_rt:8, uses:1, mr:0, br:0, e_stall:0, e_flush:0, e_pcw:1};
    tbl[8] = '{rs:1, rt:2, ex_rt:3, uses:1, mr:1, br:0, e_stall:0, e_flush:0, e_pcw:1};

    for (int k = 0; k < 3; k++) begin
      left[k] = 0; stalls[k] = 0; events[k] = 0;
    end
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    cycle();
    chk("rst.idex_stall", longint'(a_st[0]), 1);
    chk("rst.ifid_flush", longint'(a_fl[0]), 1);
    chk("rst.pc_write",   longint'(a_pw[0]), 0);
    chk("rst.busy3",      longint'(a_bz[1]), 0);
    chk("rst.stall_cycles", p_sc[0], 0);
    rst_n = 1'b1;

    // Table vectors, BUBBLES=1 instance
    for (int i = 0; i < 9; i++) begin
      rs = tbl[i].rs; rt = tbl[i].rt; ex_rt = tbl[i].ex_rt;
      uses = tbl[i].uses; mr = tbl[i].mr; br = tbl[i].br;
      cycle();
      chk($sformatf("tbl%0d.idex_stall", i), longint'(a_st[0]), longint'(tbl[i].e_stall));
      chk($sformatf("tbl%0d.ifid_flush", i), longint'(a_fl[0]), longint'(tbl[i].e_flush));
      chk($sformatf("tbl%0d.pc_write", i),   longint'(a_pw[0]), longint'(tbl[i].e_pcw));
      chk($sformatf("tbl%0d.ifid_write", i), longint'(a_iw[0]), longint'(tbl[i].e_pcw));
      if (i == 1) begin
        chk("basic.load_use_events", p_ev[0], 1);
        chk("basic.stall_cycles",    p_sc[0], 1);
      end
    end

    // BUBBLES=3: hazard held through WAIT must not extend the sequence
    do_reset();
    begin
      logic exp_st[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic exp_bz[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 4; c++) begin
        idle_inputs();
        if (c < 3) begin rs = 5'd8; ex_rt = 5'd8; mr = 1'b1; end
        cycle();
        chk($sformatf("b3.c%0d.idex_stall", c), longint'(a_st[1]), longint'(exp_st[c]));
        chk($sformatf("b3.c%0d.busy", c),       longint'(a_bz[1]), longint'(exp_bz[c]));
      end
    end
    chk("b3.stall_cycles",    p_sc[1], 3);
    chk("b3.load_use_events", p_ev[1], 1);

    // Reset during WAIT
    do_reset();
    rs = 5'd8; ex_rt = 5'd8; mr = 1'b1;
    cycle();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    chk("rstw.ifid_flush", longint'(a_fl[1]), 1);
    chk("rstw.idex_stall", longint'(a_st[1]), 1);
    chk("rstw.stall_cycles", p_sc[1], 0);
    rst_n = 1'b1;
    cycle();
    chk("rstw.busy",       longint'(a_bz[1]), 0);
    chk("rstw.pc_write",   longint'(a_pw[1]), 1);
    chk("rstw.ifid_write", longint'(a_iw[1]), 1);
    chk("rstw.idex_stall_after", longint'(a_st[1]), 0);
    chk("rstw.load_use_events", p_ev[1], 0);

    // Counter wrap on the 4-bit instance
    do_reset();
    rs = 5'd8; ex_rt = 5'd8; mr = 1'b1;
    repeat (17) cycle();
    chk("wrap.stall_cycles",    p_sc[2], 1);
    chk("wrap.load_use_events", p_ev[2], 17);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      uses  = ($urandom_range(0, 1) == 1);
      mr    = ($urandom_range(0, 1) == 1);
      br    = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Generates the stall/bubble control that drives the ID/EX pipeline register's `stall` input and the matching PC/IF-ID hold and flush signals. It detects load-use hazards between the instruction in ID and a load in EX, then sequences one or more bubble cycles through a small state machine. It also flushes IF/ID on taken branches and keeps hazard performance counters. It sits beside the ID stage and consumes the ID/EX outputs `Memread2` and `rt2`.

## Interface
- `BUBBLES`, default 1: bubbles per load-use hazard. Legal range is 1..3. Use 1 with MEM→EX forwarding; use 2 or 3 when load data is only forwarded from WB.
- `CNT_W`, default 32: width of `stall_cycles`.

Ports:
- `clk`  in  1  Pipeline clock. All state changes on the rising edge.
- `rst_n`  in  1  Reset. Synchronous and active-low.
- `id_rs`  in  5  rs field of the instruction in IF/ID.
- `id_rt`  in  5  rt field of the instruction in IF/ID.
- `id_uses_rt`  in  1  The ID instruction reads rt as a source (R-type, store, branch).
- `ex_memread`  in  1  Memread of the ID/EX register (load in EX).
- `ex_rt`  in  5  rt (load destination) of the ID/EX register.
- `id_branch_taken`  in  1  Branch resolved taken in ID this cycle.
- `idex_stall`  out  1  Drives the ID/EX `stall` input. 1 = load a bubble (all fields 0).
- `pc_write`  out  1  1 = PC may update.
- `ifid_write`  out  1  1 = IF/ID may load.
- `ifid_flush`  out  1  1 = IF/ID loads a NOP.
- `busy`  out  1  FSM is in WAIT.
- `stall_cycles`  out  CNT_W  Count of cycles with `idex_stall`=1 after reset. Wraps.
- `load_use_events`  out  16  Count of detected load-use hazards. Wraps.

## Operation
Hazard condition, combinational:
- `hz = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))`.

FSM states: RUN and WAIT. The down-counter `remain` is 2 bits.

RUN:
- `hz`=1: `idex_stall`=1, `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, and `load_use_events` increments.
  - If `BUBBLES`>1: go to WAIT and set `remain`=`BUBBLES`-1.
  - Otherwise: stay in RUN.
- `hz`=0 and `id_branch_taken`=1: `ifid_flush`=1, `pc_write`=1, `ifid_write`=1, `idex_stall`=0.
- Otherwise: all writes 1, `idex_stall`=0, `ifid_flush`=0.

WAIT:
- `idex_stall`=1, `pc_write`=0, `ifid_write`=0, `ifid_flush`=0. The `hz` and `id_branch_taken` inputs are ignored.
- `remain` decrements every cycle. When `remain`==1, the next state is RUN.
- On the cycle after returning to RUN, `hz` is re-evaluated normally.

Other rules:
- Hazard beats branch. A taken branch whose operand is the pending load must not flush; it is re-resolved after the bubble(s).
- `stall_cycles` increments on every cycle with `idex_stall`=1 while `rst_n`=1.
- `ex_rt`=0 never causes a hazard. Writes to $zero are discarded.

## Timing
- The outputs in RUN are combinational from the inputs, so the ID/EX register samples the bubble on the same edge where the hazard is present.
- The outputs in WAIT are decoded from the registered state only.
- A load-use hazard gives exactly `BUBBLES` consecutive cycles of `idex_stall`=1. During those cycles PC and IF/ID hold their values.
- While `rst_n`=0, sampled on the edge:
  - `idex_stall`=1, `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, so the pipeline registers fill with bubbles.
  - State goes to RUN, `remain`=0, `busy`=0, `stall_cycles`=0, `load_use_events`=0.
- Reset asserted during WAIT aborts the sequence. The first cycle after `rst_n` rises is RUN.
- Counter wrap: `stall_cycles` goes from all-ones to 0, and `load_use_events` goes from 0xFFFF to 0. There is no flag.

## Test plan
- **Basic load-use, `BUBBLES`=1:**
  - Stimulus: `ex_memread`=1, `ex_rt`=8, `id_rs`=8 for one cycle, then `ex_memread`=0.
  - Response: exactly 1 cycle of `idex_stall`=1 with `pc_write`=`ifid_write`=0. `load_use_events`=1, `stall_cycles`=1.
- **rt-source cases:**
  - Stimulus: `ex_rt`=9, `id_rt`=9, `id_uses_rt`=1. Response: stall.
  - Stimulus: same with `id_uses_rt`=0. Response: no stall.
  - Stimulus: `ex_rt`=0, `id_rs`=0. Response: no stall.
- **`BUBBLES`=3:**
  - Stimulus: a single hazard cycle.
  - Response: `idex_stall`=1 for 3 consecutive cycles and `busy`=1 for the last 2. A second hazard present during WAIT does not extend the sequence. `stall_cycles`=3, `load_use_events`=1.
- **Branch:**
  - Stimulus: `id_branch_taken`=1 with no hazard. Response: `ifid_flush`=1 for 1 cycle and `idex_stall`=0.
  - Stimulus: `id_branch_taken`=1 together with a hazard. Response: `ifid_flush`=0 and `idex_stall`=1.
- **Reset mid-WAIT, `BUBBLES`=3:**
  - Stimulus: drive `rst_n`=0 on the second bubble cycle, then release.
  - Response: while `rst_n`=0, `ifid_flush`=1 and `idex_stall`=1. After release: RUN, `busy`=0, counters 0, all writes 1.
- **Counter wrap:**
  - Stimulus: with `CNT_W`=4, run 17 stall cycles.
  - Response: `stall_cycles`=1.
